// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle control FSM and its ALU decoder.
// ILLEGAL_INSN_TRAP_EN adds the TRAP state encoding.
package multicycle_ctrl_pkg;

    localparam logic [4:0] ALU_ADD = 5'd0;
    localparam logic [4:0] ALU_SUB = 5'd1;
    localparam logic [4:0] ALU_AND = 5'd2;
    localparam logic [4:0] ALU_OR  = 5'd3;
    localparam logic [4:0] ALU_LUI = 5'd4;
    localparam logic [4:0] ALU_BEQ = 5'd5;
    localparam logic [4:0] ALU_BNE = 5'd6;
    localparam logic [4:0] ALU_BLT = 5'd7;
    localparam logic [4:0] ALU_BGE = 5'd8;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEM       = 3'd3,
        ST_WRITEBACK = 3'd4
`ifdef ILLEGAL_INSN_TRAP_EN
        , ST_TRAP    = 3'd5
`endif
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JAL,
        CLS_ILLEGAL
    } insn_class_t;

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// Combinational decode of opcode/funct3/funct7 into ALU function, instruction
// class and an illegal-encoding flag.
module alu_decoder
    import multicycle_ctrl_pkg::*;
#(
    parameter int ALU_FUNC_W = 5
) (
    input  logic [6:0]            opcode,
    input  logic [2:0]            funct3,
    input  logic [6:0]            funct7,
    output logic [ALU_FUNC_W-1:0] alu_func,
    output insn_class_t           cls,
    output logic                  illegal
);

    always_comb begin
        alu_func = ALU_ADD;
        cls      = CLS_ILLEGAL;
        case (opcode)
            OP_RTYPE: begin
                case (funct3)
                    3'b000: begin
                        if (funct7 == 7'b0000000) begin
                            alu_func = ALU_ADD;
                            cls      = CLS_ALU;
                        end else if (funct7 == 7'b0100000) begin
                            alu_func = ALU_SUB;
                            cls      = CLS_ALU;
                        end
                    end
                    3'b111: begin
                        alu_func = ALU_AND;
                        cls      = CLS_ALU;
                    end
                    3'b110: begin
                        alu_func = ALU_OR;
                        cls      = CLS_ALU;
                    end
                    default: ;
                endcase
            end
            OP_IMM: begin
                if (funct3 == 3'b000) begin
                    alu_func = ALU_ADD;
                    cls      = CLS_ALU;
                end
            end
            OP_LUI: begin
                alu_func = ALU_LUI;
                cls      = CLS_ALU;
            end
            OP_LOAD:  cls = CLS_LOAD;
            OP_STORE: cls = CLS_STORE;
            OP_BRANCH: begin
                case (funct3)
                    3'b000: begin alu_func = ALU_BEQ; cls = CLS_BRANCH; end
                    3'b001: begin alu_func = ALU_BNE; cls = CLS_BRANCH; end
                    3'b100: begin alu_func = ALU_BLT; cls = CLS_BRANCH; end
                    3'b101: begin alu_func = ALU_BGE; cls = CLS_BRANCH; end
                    default: ;
                endcase
            end
            OP_JAL: cls = CLS_JAL;
            default: ;
        endcase
    end

    assign illegal = (cls == CLS_ILLEGAL);

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle core: fetch, decode, execute, mem, writeback.
// Define ILLEGAL_INSN_TRAP_EN to add the TRAP state and trap output.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int ALU_FUNC_W = 5,
    parameter int STATE_W    = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            opcode,
    input  logic [2:0]            funct3,
    input  logic [6:0]            funct7,
    input  logic                  branch_taken,
    input  logic                  mem_ack,
    output logic [ALU_FUNC_W-1:0] alu_func,
    output logic                  ir_write,
    output logic                  pc_write,
    output logic                  pc_src,
    output logic                  reg_write,
    output logic [1:0]            wb_sel,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [STATE_W-1:0]    state,
    output logic                  instr_retired
`ifdef ILLEGAL_INSN_TRAP_EN
    ,
    output logic                  trap
`endif
);

    state_t                  cur_state;
    logic [ALU_FUNC_W-1:0]   dec_alu;
    insn_class_t             cls;
    logic                    illegal;
    logic                    in_exe;
    logic                    fetch_done;
    logic                    mem_done;
    logic                    exe_redirect;
    logic                    exe_retire;

    alu_decoder #(.ALU_FUNC_W(ALU_FUNC_W)) u_dec (
        .opcode   (opcode),
        .funct3   (funct3),
        .funct7   (funct7),
        .alu_func (dec_alu),
        .cls      (cls),
        .illegal  (illegal)
    );

    // mem_req is registered, so the first fetch after reset waits one idle cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= ST_FETCH;
            alu_func  <= ALU_ADD;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            wb_sel    <= WB_ALU;
`ifdef ILLEGAL_INSN_TRAP_EN
            trap      <= 1'b0;
`endif
        end else begin
            case (cur_state)
                ST_FETCH: begin
                    if (!mem_req) begin
                        mem_req <= 1'b1;
                    end else if (mem_ack) begin
                        mem_req   <= 1'b0;
                        cur_state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    cur_state <= ST_EXECUTE;
                    alu_func  <= dec_alu;
                    wb_sel    <= (cls == CLS_JAL) ? WB_PC4 : WB_ALU;
                end
                ST_EXECUTE: begin
                    alu_func  <= ALU_ADD;
                    wb_sel    <= WB_ALU;
                    mem_req   <= 1'b1;
                    cur_state <= ST_FETCH;
                    case (cls)
                        CLS_ALU: begin
                            mem_req   <= 1'b0;
                            cur_state <= ST_WRITEBACK;
                        end
                        CLS_LOAD: begin
                            wb_sel    <= WB_MEM;
                            cur_state <= ST_MEM;
                        end
                        CLS_STORE: begin
                            mem_we    <= 1'b1;
                            cur_state <= ST_MEM;
                        end
`ifdef ILLEGAL_INSN_TRAP_EN
                        CLS_ILLEGAL: begin
                            mem_req   <= 1'b0;
                            trap      <= 1'b1;
                            cur_state <= ST_TRAP;
                        end
`endif
                        default: ;
                    endcase
                end
                ST_MEM: begin
                    if (mem_ack) begin
                        // a store retires here and heads straight to the next fetch
                        mem_req   <= mem_we;
                        mem_we    <= 1'b0;
                        cur_state <= mem_we ? ST_FETCH : ST_WRITEBACK;
                    end
                end
                ST_WRITEBACK: begin
                    wb_sel    <= WB_ALU;
                    mem_req   <= 1'b1;
                    cur_state <= ST_FETCH;
                end
`ifdef ILLEGAL_INSN_TRAP_EN
                ST_TRAP: cur_state <= ST_TRAP;
`endif
                default: begin
                    alu_func  <= ALU_ADD;
                    mem_req   <= 1'b0;
                    mem_we    <= 1'b0;
                    wb_sel    <= WB_ALU;
                    cur_state <= ST_FETCH;
                end
            endcase
        end
    end

    assign in_exe       = (cur_state == ST_EXECUTE);
    assign fetch_done   = (cur_state == ST_FETCH) && mem_req && mem_ack;
    assign mem_done     = (cur_state == ST_MEM) && mem_req && mem_ack;
    assign exe_redirect = in_exe && ((cls == CLS_JAL) || ((cls == CLS_BRANCH) && branch_taken));
`ifdef ILLEGAL_INSN_TRAP_EN
    assign exe_retire   = in_exe && ((cls == CLS_BRANCH) || (cls == CLS_JAL));
`else
    assign exe_retire   = in_exe && ((cls == CLS_BRANCH) || (cls == CLS_JAL) || illegal);
`endif

    assign ir_write      = fetch_done;
    assign pc_write      = fetch_done || exe_redirect;
    assign pc_src        = exe_redirect;
    assign reg_write     = (cur_state == ST_WRITEBACK) || (in_exe && (cls == CLS_JAL));
    assign instr_retired = (cur_state == ST_WRITEBACK) || (mem_done && mem_we) || exe_retire;
    assign state         = cur_state;

endmodule
